mc_controller: RTL and testbench

Multicycle control unit for the shared-memory MIPS datapath. It sequences one instruction over 3–5 cycles through a Moore state machine and drives the enables and mux selects for the PC, instruction register, register file, ALU and unified instruction/data memory. It supports memory wait states and replaces the combinational main decoder when the core shares one memory port and one ALU across instruction phases.

---
 rtl/mc_pkg.sv | 33 +++
 rtl/aludec.sv | 16 +
 rtl/mc_controller.sv | 108 ++++++++++
 tb/tb_mc_controller.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: states, opcodes and select encodings shared by the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } mc_state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/aludec.sv
// aludec: maps aluop/funct to alucontrol; in funct,aluop; out alucontrol (unknown cases give add)
module aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);
  always_comb
    alucontrol = aluop == ALUOP_SUB   ? 3'b110 :
                 aluop != ALUOP_FUNCT ? 3'b010 :
                 funct == 6'b100010   ? 3'b110 :
                 funct == 6'b100100   ? 3'b000 :
                 funct == 6'b100101   ? 3'b001 :
                 funct == 6'b101010   ? 3'b111 : 3'b010;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore multicycle MIPS control; in clk,reset,op,funct,zero,memready; out datapath enables/selects, alucontrol, illegal, state
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);
  mc_state_t st, ns;
  logic [1:0] aluop;
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= FETCH;
    else st <= ns;
  always_comb begin
    ns = FETCH;
    iord = 1'b0;
    memwrite = 1'b0;
    irwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = SRCB_RT;
    pcsrc = PC_ALU;
    pcen = 1'b0;
    aluop = ALUOP_ADD;
    illegal = 1'b0;
    case (st)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = memready;
        pcen = memready;
        ns = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = SRCB_BRIMM;
        ns = (op == OP_LW || op == OP_SW) ? MEMADR :
             op == OP_RTYPE ? EXECUTE :
             op == OP_BEQ   ? BRANCH  :
             op == OP_ADDI  ? ADDIEX  :
             op == OP_J     ? JUMP    : FETCH;
        illegal = ns == FETCH;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        ns = op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        ns = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        memwrite = 1'b1;
        ns = memready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
        ns = ALUWB;
      end
      ALUWB: begin
        regdst = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcsrc = PC_ALUOUT;
        pcen = zero;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        ns = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc = PC_JUMP;
        pcen = 1'b1;
      end
      default: ns = FETCH;
    endcase
  end
  aludec u_aludec (.funct(funct), .aluop(aluop), .alucontrol(alucontrol));
  assign state = st;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed scoreboard bench for mc_controller
module tb_mc_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, memready = 1'b1;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [19:0] obs;
  logic [19:0] q[$];
  string tq[$];
  int checks = 0, errors = 0;
  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
    S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11;
  localparam logic [2:0] ADD = 3'b010, SLT = 3'b111, SUB = 3'b110;
  mc_controller dut (.clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal), .state(state));
  always #5 clk = ~clk;
  assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc,
                pcen, alucontrol, illegal, state};
  function automatic logic [19:0] expv(input logic [3:0] st, input logic pe, input logic [2:0] ac,
                                       input logic il);
    logic io, mw, irw, rd, mtr, rw, asa;
    logic [1:0] asb, ps;
    {io, mw, irw, rd, mtr, rw, asa, asb, ps} = '0;
    case (st)
      S_FETCH:   begin asb = 2'b01; irw = pe; end
      S_DECODE:  asb = 2'b11;
      S_MEMADR:  begin asa = 1'b1; asb = 2'b10; end
      S_MEMRD:   io = 1'b1;
      S_MEMWB:   begin mtr = 1'b1; rw = 1'b1; end
      S_MEMWR:   begin io = 1'b1; mw = 1'b1; end
      S_EXECUTE: asa = 1'b1;
      S_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
      S_BRANCH:  begin asa = 1'b1; ps = 2'b01; end
      S_ADDIEX:  begin asa = 1'b1; asb = 2'b10; end
      S_ADDIWB:  rw = 1'b1;
      S_JUMP:    ps = 2'b10;
      default: ;
    endcase
    return {io, mw, irw, rd, mtr, rw, asa, asb, ps, pe, ac, il, st};
  endfunction
  task automatic step(input string t, input logic [3:0] st, input logic pe = 1'b0,
                      input logic [2:0] ac = ADD, input logic il = 1'b0);
    logic [19:0] e;
    string tg;
    q.push_back(expv(st, pe, ac, il));
    tq.push_back(t);
    @(negedge clk);
    e = q.pop_front();
    tg = tq.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, e);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    step("reset_fetch", S_FETCH, 1'b1);
    reset = 1'b0;
    op = 6'b101011;
    step("sw_fetch", S_FETCH, 1'b1);
    step("sw_decode", S_DECODE);
    step("sw_memadr", S_MEMADR);
    memready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw_wait", S_MEMWR);
    memready = 1'b1;
    step("sw_done", S_MEMWR);
    step("sw_back", S_FETCH, 1'b1);
    step("sw2_decode", S_DECODE);
    step("sw2_memadr", S_MEMADR);
    memready = 1'b0;
    step("sw2_memwr", S_MEMWR);
    reset = 1'b1;
    #1;
    step("reset_mid_memwr", S_FETCH, 1'b0);
    reset = 1'b0;
    step("post_reset_wait", S_FETCH, 1'b0);
    memready = 1'b1;
    op = 6'b100011;
    step("lw_fetch", S_FETCH, 1'b1);
    step("lw_decode", S_DECODE);
    step("lw_memadr", S_MEMADR);
    step("lw_memrd", S_MEMRD);
    step("lw_memwb", S_MEMWB);
    op = 6'b000000;
    funct = 6'b101010;
    step("r_fetch", S_FETCH, 1'b1);
    step("r_decode", S_DECODE);
    step("r_execute", S_EXECUTE, 1'b0, SLT);
    step("r_aluwb", S_ALUWB);
    op = 6'b000100;
    zero = 1'b1;
    step("beq1_fetch", S_FETCH, 1'b1);
    step("beq1_decode", S_DECODE);
    step("beq_taken", S_BRANCH, 1'b1, SUB);
    zero = 1'b0;
    step("beq0_fetch", S_FETCH, 1'b1);
    step("beq0_decode", S_DECODE);
    step("beq_not_taken", S_BRANCH, 1'b0, SUB);
    op = 6'b001000;
    step("addi_fetch", S_FETCH, 1'b1);
    step("addi_decode", S_DECODE);
    step("addi_ex", S_ADDIEX);
    step("addi_wb", S_ADDIWB);
    op = 6'b111111;
    step("ill_fetch", S_FETCH, 1'b1);
    step("ill_decode", S_DECODE, 1'b0, ADD, 1'b1);
    op = 6'b000010;
    step("j_fetch", S_FETCH, 1'b1);
    step("j_decode", S_DECODE);
    step("j_jump", S_JUMP, 1'b1);
    step("final_fetch", S_FETCH, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
